// File: rtl/calc_keys_pkg.sv
`default_nettype none
// ============================================================================
// calc_keys_pkg : key codes, keypad map and scanner state encoding shared by
//                 the keypad scanner and the calculator datapath.
// Rev 1.0
// ============================================================================
package calc_keys_pkg;

  localparam logic [4:0] KEY_NONE = 5'h10;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_MUL  = 4'hC;
  localparam logic [3:0] KEY_DIV  = 4'hD;
  localparam logic [3:0] KEY_BACK = 4'hE;
  localparam logic [3:0] KEY_CLR  = 4'hF;

  localparam logic [1:0] ST_SCAN    = 2'd0;
  localparam logic [1:0] ST_DEBNC   = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Indexed by row*4+col; physical layout row0 = "1 2 3 +" ... row3 = "<- 0 C /".
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1,     4'h2, 4'h3,    KEY_ADD,
    4'h4,     4'h5, 4'h6,    KEY_SUB,
    4'h7,     4'h8, 4'h9,    KEY_MUL,
    KEY_BACK, 4'h0, KEY_CLR, KEY_DIV
  };

  function automatic logic [4:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {1'b0, KEYMAP[{row, col}]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_row_sync.sv
`default_nettype none
// ============================================================================
// keypad_row_sync : 2-FF synchroniser for the four keypad row inputs.
// Rev 1.0
// ============================================================================
module keypad_row_sync (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] row_in,
  output logic [3:0] row_sync
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Resets to all-released so no phantom press is seen after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_meta <= 4'hF;
      r_sync <= 4'hF;
    end else begin
      r_meta <= row_in;
      r_sync <= r_meta;
    end
  end

  assign row_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// keypad_scan_ctrl : 4x4 active-low keypad scanner, debouncer and key-code bus.
// Optional auto-repeat of held keys: define KEYPAD_REPEAT_EN.
// Rev 1.0
// ============================================================================
module keypad_scan_ctrl
  import calc_keys_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_DLY   = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [4:0] key_stats,
  output logic       key_valid
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam int REP_W = (REPEAT_DLY > 2) ? $clog2(REPEAT_DLY) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DLY - 1);
  localparam logic [REP_W-1:0] REP_GAP  = REP_W'(REPEAT_DLY - 2);

`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    SCAN    = ST_SCAN,
    DEBNC   = ST_DEBNC,
    PRESSED = ST_PRESSED,
    RELEASE = ST_RELEASE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col, w_col_nxt;
  logic [1:0]       r_row, w_row_nxt;
  logic [DEB_W-1:0] r_cnt, w_cnt_nxt;
  logic [REP_W-1:0] r_rep, w_rep_nxt;
  logic [4:0]       r_stats, w_stats_nxt;
  logic             r_valid, w_valid_nxt;
  logic [3:0]       r_col_out;

  logic [3:0]       w_rows;
  logic [1:0]       w_low_idx;
  logic             w_sample;
  logic             w_any_low;
  logic             w_rep_ok;

  keypad_row_sync u_row_sync (
    .CLK      (CLK),
    .RST      (RST),
    .row_in   (row_in),
    .row_sync (w_rows)
  );

  assign w_sample  = (r_div == DIV_LAST);
  assign w_any_low = (w_rows != 4'hF);
  // Backspace and clear are destructive, so they never auto-repeat.
  assign w_rep_ok  = REPEAT_ON && (KEYMAP[{r_row, r_col}] < KEY_BACK);

  always_comb begin
    w_low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!w_rows[i]) w_low_idx = 2'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_rep_nxt   = r_rep;
    w_stats_nxt = r_stats;
    w_valid_nxt = 1'b0;
    if (w_sample) begin
      case (r_state)
        SCAN: begin
          if (w_any_low) begin
            w_row_nxt = w_low_idx;
            w_cnt_nxt = DEB_W'(1);
            if (DEBOUNCE_CNT <= 1) begin
              w_state_nxt = PRESSED;
              w_stats_nxt = key_code(w_low_idx, r_col);
              w_valid_nxt = 1'b1;
              w_rep_nxt   = '0;
            end else begin
              w_state_nxt = DEBNC;
            end
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
        DEBNC: begin
          if (!w_rows[r_row]) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == DEB_LAST) begin
              w_state_nxt = PRESSED;
              w_stats_nxt = key_code(r_row, r_col);
              w_valid_nxt = 1'b1;
              w_rep_nxt   = '0;
            end
          end else begin
            w_state_nxt = SCAN;
            w_col_nxt   = r_col + 2'd1;
          end
        end
        PRESSED: begin
          if (!w_any_low) begin
            w_cnt_nxt = DEB_W'(1);
            if (DEBOUNCE_CNT <= 1) begin
              w_state_nxt = SCAN;
              w_col_nxt   = 2'd0;
              w_stats_nxt = KEY_NONE;
            end else begin
              w_state_nxt = RELEASE;
            end
          end else if (w_rep_ok) begin
            // One dwell of KEY_NONE precedes each repeat so change detection fires.
            if (r_rep == REP_LAST) begin
              w_stats_nxt = key_code(r_row, r_col);
              w_valid_nxt = 1'b1;
              w_rep_nxt   = '0;
            end else begin
              w_rep_nxt = r_rep + 1'b1;
              if (r_rep == REP_GAP) w_stats_nxt = KEY_NONE;
            end
          end
        end
        RELEASE: begin
          if (!w_any_low) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == DEB_LAST) begin
              w_state_nxt = SCAN;
              w_col_nxt   = 2'd0;
              w_stats_nxt = KEY_NONE;
            end
          end else begin
            w_state_nxt = PRESSED;
          end
        end
        default: w_state_nxt = SCAN;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= SCAN;
      r_div     <= '0;
      r_col     <= 2'd0;
      r_row     <= 2'd0;
      r_cnt     <= '0;
      r_rep     <= '0;
      r_stats   <= KEY_NONE;
      r_valid   <= 1'b0;
      r_col_out <= 4'b1110;
    end else begin
      r_div     <= w_sample ? '0 : r_div + 1'b1;
      r_state   <= w_state_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rep     <= w_rep_nxt;
      r_stats   <= w_stats_nxt;
      r_valid   <= w_valid_nxt;
      r_col_out <= ~(4'b0001 << w_col_nxt);
    end
  end

  assign col_out   = r_col_out;
  assign key_stats = r_stats;
  assign key_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_keypad_scan_ctrl : keypad matrix model, per-cycle reference model of the
//                       scanner and directed press/bounce/release scenarios.
// Rev 1.0
// ============================================================================
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_DLY   = 5;
  localparam int DWELL        = SCAN_DIV;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [4:0]  key_stats;
  logic        key_valid;
  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;

  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  logic [3:0] exp_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 CLK = ~CLK;

  keypad_scan_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_DLY   (REPEAT_DLY)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_stats (key_stats),
    .key_valid (key_valid)
  );

  // Closed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // ---------------- reference model ----------------
  int         m_phase = 0;   // 0 hunting, 1 confirming, 2 held, 3 letting go
  int         m_col   = 0;
  int         m_row   = 0;
  int         m_n     = 0;
  int         m_tick  = 0;
  int         m_code  = 16;
  int         m_since = 0;
  bit         m_valid = 1'b0;
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_smp;
`ifdef KEYPAD_REPEAT_EN
  bit         m_repeat = 1'b1;
`else
  bit         m_repeat = 1'b0;
`endif

  function automatic logic [3:0] rows_seen(input int col);
    logic [3:0] r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      if (keys[rr*4+col]) r[rr] = 1'b0;
    return r;
  endfunction

  task automatic accept_key();
    m_phase = 2;
    m_code  = keymap[m_row*4+m_col];
    m_valid = 1'b1;
    m_since = 0;
  endtask

  task automatic model_sample(input logic [3:0] rows);
    bit any = (rows != 4'hF);
    int low = 0;
    for (int r = 3; r >= 0; r--) if (!rows[r]) low = r;
    case (m_phase)
      0: if (any) begin
           m_row = low; m_n = 1;
           if (m_n >= DEBOUNCE_CNT) accept_key(); else m_phase = 1;
         end else m_col = (m_col + 1) % 4;
      1: if (!rows[m_row]) begin
           m_n++;
           if (m_n == DEBOUNCE_CNT) accept_key();
         end else begin
           m_phase = 0; m_col = (m_col + 1) % 4;
         end
      2: if (!any) begin
           m_phase = 3; m_n = 1;
         end else if (m_repeat && keymap[m_row*4+m_col] < 14) begin
           m_since++;
           if (m_since == REPEAT_DLY - 1) m_code = 16;
           else if (m_since == REPEAT_DLY) begin
             m_code = keymap[m_row*4+m_col]; m_valid = 1'b1; m_since = 0;
           end
         end
      default: if (!any) begin
           m_n++;
           if (m_n == DEBOUNCE_CNT) begin m_phase = 0; m_col = 0; m_code = 16; end
         end else m_phase = 2;
    endcase
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_phase = 0; m_col = 0; m_row = 0; m_n = 0; m_tick = 0;
      m_code = 16; m_since = 0; m_valid = 1'b0; m_s1 = 4'hF; m_s2 = 4'hF;
    end else begin
      m_smp   = m_s2;
      m_s2    = m_s1;
      m_s1    = rows_seen(m_col);
      m_valid = 1'b0;
      if (m_tick == SCAN_DIV - 1) begin
        m_tick = 0;
        model_sample(m_smp);
      end else m_tick++;
    end
  end

  // Every cycle out of reset the outputs must equal the model.
  always @(negedge CLK) begin
    if (!RST) begin
      n_checks++;
      if (col_out === ~(4'b0001 << m_col) && key_stats === 5'(m_code) && key_valid === m_valid)
        n_pass++;
      else
        $display("FAIL cycle_model t=%0t: got col=%b stats=%h valid=%b, want col=%b stats=%h valid=%b",
                 $time, col_out, key_stats, key_valid, ~(4'b0001 << m_col), 5'(m_code), m_valid);
      if (key_valid) n_pulses++;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (key_valid !== 1'b1 && k < budget) begin @(negedge CLK); k++; end
    check(name, 32'(key_valid), 32'h1);
  endtask

  task automatic wait_none(input string name, input int budget, output int cycles);
    cycles = 0;
    while (key_stats !== 5'h10 && cycles < budget) begin @(negedge CLK); cycles++; end
    check(name, 32'(key_stats), 32'h10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int p0, cyc, ns;
    logic [3:0] seen [4];
    logic [3:0] last;

    // 1. reset values and idle column rotation
    repeat (3) @(negedge CLK);
    check("reset_col_out",   32'(col_out),   32'hE);
    check("reset_key_stats", 32'(key_stats), 32'h10);
    check("reset_key_valid", 32'(key_valid), 32'h0);
    RST = 1'b0;
    seen[0] = col_out; last = col_out; ns = 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (col_out !== last && ns < 4) begin seen[ns] = col_out; ns++; end
      last = col_out;
    end
    for (int i = 0; i < 4; i++) check($sformatf("idle_col_seq%0d", i), 32'(seen[i]), 32'(exp_seq[i]));

    // 2. clean press of row1/col2 ('6'), then release
    p0 = n_pulses;
    keys[6] = 1'b1;
    wait_valid("t2_press_valid", 40);
    check("t2_code",   32'(key_stats), 32'h06);
    check("t2_locked", 32'(col_out),   32'hB);
    repeat (20) @(negedge CLK);
    check("t2_one_pulse", 32'(n_pulses - p0), 32'd1);
    keys = '0;
    wait_none("t2_release_none", 30, cyc);
    check("t2_release_latency", 32'(cyc >= 2*DWELL+1 && cyc <= 4*DWELL), 32'h1);

    // 3. bouncing press and release of '5'
    repeat (4*DWELL) @(negedge CLK);
    p0 = n_pulses;
    for (int i = 0; i < 12; i++) begin
      keys[5] = (i % 2 == 0);
      repeat (DWELL) @(negedge CLK);
    end
    check("t3_bounce_no_pulse", 32'(n_pulses - p0), 32'd0);
    keys[5] = 1'b1;
    wait_valid("t3_stable_valid", 40);
    check("t3_code", 32'(key_stats), 32'h05);
    repeat (2*DWELL) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      keys[5] = (i % 2 == 1);
      repeat (DWELL) @(negedge CLK);
    end
    keys = '0;
    wait_none("t3_release_none", 40, cyc);
    check("t3_single_pulse", 32'(n_pulses - p0), 32'd1);

    // 4. same key twice with full release between
    p0 = n_pulses;
    keys[6] = 1'b1;
    wait_valid("t4_first_valid", 40);
    check("t4_first_code", 32'(key_stats), 32'h06);
    repeat (DWELL) @(negedge CLK);
    keys = '0;
    wait_none("t4_gap_none", 40, cyc);
    keys[6] = 1'b1;
    wait_valid("t4_second_valid", 40);
    check("t4_second_code", 32'(key_stats), 32'h06);
    repeat (DWELL) @(negedge CLK);
    keys = '0;
    wait_none("t4_end_none", 40, cyc);
    check("t4_two_pulses", 32'(n_pulses - p0), 32'd2);

    // 5. col0 ('4') and col3 ('+') together at the start of a col0 dwell, then reset
    cyc = 0;
    while (col_out === 4'b1110 && cyc < 40) begin @(negedge CLK); cyc++; end
    while (col_out !== 4'b1110 && cyc < 80) begin @(negedge CLK); cyc++; end
    check("t5_col0_found", 32'(col_out), 32'hE);
    keys[4] = 1'b1;
    keys[3] = 1'b1;
    wait_valid("t5_valid", 40);
    check("t5_col0_wins", 32'(key_stats), 32'h04);
    repeat (2*DWELL) @(negedge CLK);
    check("t5_still_col0", 32'(key_stats), 32'h04);
    check("t5_col_locked", 32'(col_out),   32'hE);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    check("t5_rst_col_out",   32'(col_out),   32'hE);
    check("t5_rst_key_stats", 32'(key_stats), 32'h10);
    check("t5_rst_key_valid", 32'(key_valid), 32'h0);
    @(negedge CLK);
    keys = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (4*DWELL) @(negedge CLK);

`ifdef KEYPAD_REPEAT_EN
    // 6. auto-repeat on '5', none on 'C'
    p0 = n_pulses;
    keys[5] = 1'b1;
    wait_valid("t6_first_valid", 40);
    check("t6_code", 32'(key_stats), 32'h05);
    repeat (28*DWELL) @(negedge CLK);
    keys = '0;
    wait_none("t6_release_none", 40, cyc);
    check("t6_repeat_pulses", 32'(n_pulses - p0), 32'd6);
    p0 = n_pulses;
    keys[14] = 1'b1;
    wait_valid("t6_clr_valid", 40);
    check("t6_clr_code", 32'(key_stats), 32'h0F);
    repeat (30*DWELL) @(negedge CLK);
    keys = '0;
    wait_none("t6_clr_release", 40, cyc);
    check("t6_clr_single", 32'(n_pulses - p0), 32'd1);
`endif

    repeat (DWELL) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
